// File: rtl/uart_ctrl_pkg.sv
// Shared types and constants for the UART transmit-side control blocks.
package uart_ctrl_pkg;

  localparam int UART_BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_ACCEPT,
    WAIT_DONE
  } uart_arb_state_t;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational circular first-one finder: returns the first set bit of
// eligible, searching upward from ptr and wrapping modulo NUM_REQ.
module uart_rr_pick #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [IDX_W-1:0]   ptr,
  output logic               found,
  output logic [IDX_W-1:0]   index
);

  logic [NUM_REQ-1:0] rot;
  logic [IDX_W-1:0]   rot_idx [NUM_REQ];

  // rot[k] is the requester k places after the pointer
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
      logic [IDX_W:0] sum;
      assign sum         = {1'b0, ptr} + (IDX_W+1)'(gi);
      assign rot_idx[gi] = (sum >= (IDX_W+1)'(NUM_REQ)) ?
                           IDX_W'(sum - (IDX_W+1)'(NUM_REQ)) : IDX_W'(sum);
      assign rot[gi]     = eligible[rot_idx[gi]];
    end
  endgenerate

  always_comb begin
    found = 1'b0;
    index = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        index = rot_idx[k];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter sharing one UART TX engine between NUM_REQ
// byte streams, one byte per start/busy handshake, with a per-grant burst cap.
module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int DATA_W    = UART_BYTE_W,
  parameter  int MAX_BURST = 16,
  localparam int IDX_W     = $clog2(NUM_REQ)
) (
  input  logic                      ACLK,
  input  logic                      ARESETN,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      arb_enable,
  input  logic [NUM_REQ-1:0]        req_mask,
  output logic [DATA_W-1:0]         tx_data,
  output logic                      tx_start,
  input  logic                      tx_busy,
  output logic                      grant_active,
  output logic [IDX_W-1:0]          grant_id
);

  uart_arb_state_t    state_reg, state_next;
  logic [IDX_W-1:0]   ptr_reg, ptr_next;
  logic [IDX_W-1:0]   gid_reg, gid_next;
  logic               active_reg, active_next;
  logic [7:0]         burst_reg, burst_next;
  logic               last_reg, last_next;
  logic [DATA_W-1:0]  tx_data_reg, tx_data_next;
  logic               tx_start_reg, tx_start_next;

  logic [DATA_W-1:0]  byte_arr [NUM_REQ];
  logic [NUM_REQ-1:0] eligible;
  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic               sel_valid, sel_mask, sel_last;
  logic               issue_hs;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign byte_arr[gi]  = req_data[gi*DATA_W +: DATA_W];
      assign req_ready[gi] = issue_hs && (gid_reg == IDX_W'(gi));
    end
  endgenerate

  assign eligible  = req_valid & req_mask;
  assign sel_valid = req_valid[gid_reg];
  assign sel_mask  = req_mask[gid_reg];
  assign sel_last  = req_last[gid_reg];
  // A masked-off grantee is never handed a ready, even if it is valid
  assign issue_hs  = (state_reg == ISSUE) && sel_valid && sel_mask;

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .eligible (eligible),
    .ptr      (ptr_reg),
    .found    (pick_found),
    .index    (pick_idx)
  );

  always_comb begin
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    gid_next      = gid_reg;
    active_next   = active_reg;
    burst_next    = burst_reg;
    last_next     = last_reg;
    tx_data_next  = tx_data_reg;
    tx_start_next = 1'b0;

    case (state_reg)
      IDLE: begin
        if (arb_enable && pick_found) begin
          gid_next    = pick_idx;
          active_next = 1'b1;
          burst_next  = '0;
          state_next  = ISSUE;
        end
      end
      ISSUE: begin
        if (!sel_mask) begin
          active_next = 1'b0;
          ptr_next    = (gid_reg == IDX_W'(NUM_REQ - 1)) ? '0 : gid_reg + 1'b1;
          state_next  = IDLE;
        end else if (sel_valid) begin
          tx_data_next  = byte_arr[gid_reg];
          tx_start_next = 1'b1;
          burst_next    = burst_reg + 8'd1;
          last_next     = sel_last;
          state_next    = WAIT_ACCEPT;
        end
      end
      WAIT_ACCEPT: begin
        if (tx_busy) begin
          state_next = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          if (last_reg || (burst_reg == 8'(MAX_BURST))) begin
            active_next = 1'b0;
            ptr_next    = (gid_reg == IDX_W'(NUM_REQ - 1)) ? '0 : gid_reg + 1'b1;
            state_next  = IDLE;
          end else begin
            state_next = ISSUE;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_reg    <= IDLE;
      ptr_reg      <= '0;
      gid_reg      <= '0;
      active_reg   <= 1'b0;
      burst_reg    <= '0;
      last_reg     <= 1'b0;
      tx_data_reg  <= '0;
      tx_start_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      gid_reg      <= gid_next;
      active_reg   <= active_next;
      burst_reg    <= burst_next;
      last_reg     <= last_next;
      tx_data_reg  <= tx_data_next;
      tx_start_reg <= tx_start_next;
    end
  end

  assign tx_data      = tx_data_reg;
  assign tx_start     = tx_start_reg;
  assign grant_active = active_reg;
  assign grant_id     = gid_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter: packet-level reference model of the
// round-robin/burst rules plus a behavioural TX engine with variable timing.
module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int MB = 4;
  localparam int IW = 2;
  localparam int QD = 64;

  logic              ACLK = 1'b0;
  logic              ARESETN = 1'b0;
  logic [NR-1:0]     req_valid;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     req_last;
  logic [NR-1:0]     req_ready;
  logic              arb_enable;
  logic [NR-1:0]     req_mask;
  logic [DW-1:0]     tx_data;
  logic              tx_start;
  logic              tx_busy;
  logic              grant_active;
  logic [IW-1:0]     grant_id;

  always #5 ACLK = ~ACLK;

  uart_tx_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .ACLK         (ACLK),
    .ARESETN      (ARESETN),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .arb_enable   (arb_enable),
    .req_mask     (req_mask),
    .tx_data      (tx_data),
    .tx_start     (tx_start),
    .tx_busy      (tx_busy),
    .grant_active (grant_active),
    .grant_id     (grant_id)
  );

  int errors = 0;
  int checks = 0;

  // Driver byte queues ({last,data}) and the model's private copies
  logic [8:0] dq [NR][QD];
  int         dh [NR];
  int         dc [NR];
  logic [8:0] mq [NR][QD];
  int         mh [NR];
  int         mc [NR];
  int         mptr;
  int         exp_q [$];

  int rise_cfg, len_cfg;
  bit rand_eng;
  int eng_phase, eng_rise, eng_len;
  int n_starts;
  bit prev_start;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic push_byte(input int id, input int b, input bit last, input bit to_model);
    dq[id][(dh[id] + dc[id]) % QD] = {last, 8'(b)};
    dc[id]++;
    if (to_model) begin
      mq[id][(mh[id] + mc[id]) % QD] = {last, 8'(b)};
      mc[id]++;
    end
  endtask

  task automatic push_pkt(input int id, input int len);
    for (int k = 0; k < len; k++)
      push_byte(id, $urandom_range(0, 255), (k == len - 1), 1'b1);
  endtask

  // Packet-level arbitration: circular pick, up to MB bytes or the last flag
  task automatic model_drain();
    int g, cnt;
    logic [8:0] e;
    forever begin
      g = -1;
      for (int k = 0; k < NR; k++)
        if (g < 0 && mc[(mptr + k) % NR] > 0) g = (mptr + k) % NR;
      if (g < 0) break;
      cnt = 0;
      while (mc[g] > 0) begin
        e = mq[g][mh[g]];
        mh[g] = (mh[g] + 1) % QD;
        mc[g]--;
        exp_q.push_back(g * 256 + int'(e[7:0]));
        cnt++;
        if (e[8] || cnt == MB) break;
      end
      mptr = (g + 1) % NR;
    end
  endtask

  function automatic bit all_idle();
    bit r;
    r = (exp_q.size() == 0) && (eng_phase == 0) && (grant_active == 1'b0);
    for (int i = 0; i < NR; i++) if (dc[i] != 0) r = 1'b0;
    return r;
  endfunction

  task automatic wait_idle(input string tag);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 4000 && !done; c++) begin
      @(negedge ACLK);
      done = all_idle();
    end
    check({tag, "_drained"}, 32'(done), 32'd1);
    $display("phase %s complete: starts=%0d", tag, n_starts);
  endtask

  // Requester driver, TX engine model and byte monitor, all on the falling edge
  initial begin
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    tx_busy   = 1'b0;
    forever begin
      @(negedge ACLK);
      if (!ARESETN) begin
        for (int i = 0; i < NR; i++) begin dh[i] = 0; dc[i] = 0; end
        eng_phase  = 0;
        tx_busy    = 1'b0;
        prev_start = 1'b0;
        exp_q.delete();
      end else begin
        if (tx_start) begin
          check("start_idle", 32'(eng_phase), 32'd0);
          check("start_pulse", 32'(prev_start), 32'd0);
          if (exp_q.size() == 0) check("byte_extra", {grant_id, tx_data}, 32'hFFFF);
          else check("byte", 32'(int'(grant_id) * 256 + int'(tx_data)), 32'(exp_q.pop_front()));
          $display("tx byte: req=%0d data=%02h", grant_id, tx_data);
          if (dc[grant_id] > 0) begin
            dh[grant_id] = (dh[grant_id] + 1) % QD;
            dc[grant_id]--;
          end
          n_starts++;
          eng_phase = 1;
          eng_rise  = rand_eng ? $urandom_range(0, 3) : rise_cfg;
          eng_len   = rand_eng ? $urandom_range(1, 5) : len_cfg;
        end
        prev_start = tx_start;
        if (eng_phase == 1) begin
          if (eng_rise == 0) begin tx_busy = 1'b1; eng_phase = 2; end
          else eng_rise--;
        end else if (eng_phase == 2) begin
          if (eng_len == 0) begin tx_busy = 1'b0; eng_phase = 0; end
          else eng_len--;
        end
      end
      for (int i = 0; i < NR; i++) begin
        req_valid[i]         = (dc[i] > 0);
        req_data[i*DW +: DW] = dq[i][dh[i]][7:0];
        req_last[i]          = dq[i][dh[i]][8];
      end
    end
  end

  initial begin
    int s0;
    bit seen;
    arb_enable = 1'b0;
    req_mask   = '1;
    rise_cfg   = 0;
    len_cfg    = 10;
    rand_eng   = 1'b0;
    n_starts   = 0;
    mptr       = 0;
    eng_phase  = 0;
    for (int i = 0; i < NR; i++) begin dh[i] = 0; dc[i] = 0; mh[i] = 0; mc[i] = 0; end

    repeat (3) @(negedge ACLK);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_start", 32'(tx_start), 32'd0);
    check("rst_data", 32'(tx_data), 32'd0);
    check("rst_active", 32'(grant_active), 32'd0);
    check("rst_gid", 32'(grant_id), 32'd0);
    ARESETN = 1'b1;

    // Single requester, two bytes, with grant/start latency
    push_byte(1, 8'h41, 1'b0, 1'b1);
    push_byte(1, 8'h42, 1'b1, 1'b1);
    model_drain();
    @(negedge ACLK);
    arb_enable = 1'b1;
    @(negedge ACLK);
    check("lat_active", 32'(grant_active), 32'd1);
    check("lat_gid", 32'(grant_id), 32'd1);
    check("lat_ready", 32'(req_ready), 32'b0010);
    check("lat_nostart", 32'(tx_start), 32'd0);
    @(negedge ACLK);
    check("lat_start", 32'(tx_start), 32'd1);
    wait_idle("single");
    check("single_gid", 32'(grant_id), 32'd1);

    // Fairness: everyone pending with one-byte packets, delayed busy rise
    rise_cfg = 3; len_cfg = 2;
    arb_enable = 1'b0;
    for (int r = 0; r < 2; r++) for (int i = 0; i < NR; i++) push_pkt(i, 1);
    model_drain();
    @(negedge ACLK);
    arb_enable = 1'b1;
    wait_idle("fair");

    // Burst limit splits a 6-byte packet around a competing requester
    arb_enable = 1'b0;
    push_pkt(2, 6);
    push_pkt(3, 1);
    model_drain();
    @(negedge ACLK);
    arb_enable = 1'b1;
    wait_idle("burst");

    // Random traffic and engine timing
    rand_eng = 1'b1;
    for (int r = 0; r < 6; r++) begin
      arb_enable = 1'b0;
      for (int n = $urandom_range(1, 5); n > 0; n--)
        push_pkt($urandom_range(0, NR - 1), $urandom_range(1, 7));
      model_drain();
      @(negedge ACLK);
      arb_enable = 1'b1;
      wait_idle("random");
    end
    rand_eng = 1'b0;
    rise_cfg = 0; len_cfg = 3;

    // Packet lock with valid low, then released by the mask
    arb_enable = 1'b0;
    push_byte(0, 8'h5A, 1'b0, 1'b0);
    exp_q.push_back(8'h5A);
    @(negedge ACLK);
    arb_enable = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge ACLK);
      seen = (dc[0] == 0) && (eng_phase == 0);
    end
    repeat (10) @(negedge ACLK);
    s0 = n_starts;
    check("lock_active", 32'(grant_active), 32'd1);
    check("lock_gid", 32'(grant_id), 32'd0);
    check("lock_ready", 32'(req_ready), 32'd0);
    repeat (10) @(negedge ACLK);
    check("lock_nostart", 32'(n_starts), 32'(s0));
    req_mask = 4'b1110;
    @(negedge ACLK);
    check("mask_release", 32'(grant_active), 32'd0);
    check("mask_nostart", 32'(n_starts), 32'(s0));
    req_mask = '1;
    mptr = 1;
    repeat (2) @(negedge ACLK);

    // arb_enable low blocks new grants but not a packet in flight
    arb_enable = 1'b0;
    push_pkt(1, 3);
    model_drain();
    s0 = n_starts;
    repeat (20) @(negedge ACLK);
    check("en_block", 32'(grant_active), 32'd0);
    check("en_nostart", 32'(n_starts), 32'(s0));
    arb_enable = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge ACLK);
      seen = (n_starts > s0);
    end
    check("en_started", 32'(seen), 32'd1);
    arb_enable = 1'b0;
    wait_idle("enable");
    check("en_finish", 32'(n_starts), 32'(s0 + 3));
    arb_enable = 1'b1;

    // Reset in the middle of a packet
    len_cfg = 10;
    arb_enable = 1'b0;
    push_byte(3, 8'h11, 1'b0, 1'b0);
    push_byte(3, 8'h22, 1'b0, 1'b0);
    push_byte(3, 8'h33, 1'b1, 1'b0);
    exp_q.push_back(3 * 256 + 8'h11);
    @(negedge ACLK);
    arb_enable = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge ACLK);
      seen = tx_busy;
    end
    check("rst_busy_seen", 32'(seen), 32'd1);
    repeat (2) @(negedge ACLK);
    #2 ARESETN = 1'b0;
    #1;
    check("mid_rst_ready", 32'(req_ready), 32'd0);
    check("mid_rst_start", 32'(tx_start), 32'd0);
    check("mid_rst_data", 32'(tx_data), 32'd0);
    check("mid_rst_active", 32'(grant_active), 32'd0);
    check("mid_rst_gid", 32'(grant_id), 32'd0);
    repeat (3) @(negedge ACLK);
    arb_enable = 1'b0;
    ARESETN = 1'b1;
    @(negedge ACLK);
    mptr = 0;
    push_pkt(2, 2);
    push_pkt(1, 1);
    model_drain();
    @(negedge ACLK);
    arb_enable = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge ACLK);
      seen = grant_active;
    end
    check("post_rst_grant", 32'(seen), 32'd1);
    check("post_rst_gid", 32'(grant_id), 32'd1);
    wait_idle("reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
